// File: rtl/bus_hs_pkg.sv
// Shared types and constants for the valid/ready beat receiver.
// STALL_MASK only matters when BACKPRESSURE_EN is defined.
package bus_hs_pkg;

    localparam int DATA_W  = 3;
    localparam int BEATS   = 3;
    localparam int FRAME_W = DATA_W * BEATS;
    localparam int CNT_W   = $clog2(BEATS + 1);

    localparam logic [7:0] STALL_MASK = 8'hA4;

    localparam logic [DATA_W-1:0] EXP_BEAT [0:BEATS-1] = '{3'b111, 3'b101, 3'b110};

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } rx_state_t;

    // Earlier beats move up one slot, so beat 0 ends in the top bits.
    function automatic logic [FRAME_W-1:0] pack_beat(input logic [FRAME_W-1:0] acc,
                                                     input logic [DATA_W-1:0]  beat);
        return (acc << DATA_W) | FRAME_W'(beat);
    endfunction

endpackage

// File: rtl/slave_stall_gen.sv
// Rotating-mask ready throttle. Only instantiated when BACKPRESSURE_EN is defined.
module slave_stall_gen #(
    parameter logic [7:0] MASK = 8'hA4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic stall
);

    logic [7:0] stall_sr;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stall_sr <= MASK;
        end else begin
            stall_sr <= {stall_sr[0], stall_sr[7:1]};
        end
    end

    assign stall = stall_sr[0];

endmodule

// File: rtl/slave_rx.sv
// Beat receiver: packs BEATS beats into a frame, checks them against EXP_BEAT and
// holds the frame in a one-entry buffer. BACKPRESSURE_EN adds a ready_up throttle.
//   state | meaning
//   IDLE  | waiting for beat 0
//   RECV  | collecting beats 1..BEATS-1
//   HOLD  | frame presented downstream, no beats accepted
module slave_rx
    import bus_hs_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               valid_up,
    input  logic [DATA_W-1:0]  data_up,
    output logic               ready_up,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    output logic               frame_err,
    input  logic               frame_ready,
    output logic [7:0]         abort_cnt
);

    rx_state_t          state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [FRAME_W-1:0] asm_data;
    logic               err_acc;
    logic               stall;
    logic               mismatch;

`ifdef BACKPRESSURE_EN
    slave_stall_gen #(.MASK(STALL_MASK)) u_stall_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .stall   (stall)
    );
`else
    assign stall = 1'b0;
`endif

    // Independent of valid_up so the handshake has no combinational loop.
    assign ready_up = (state != HOLD) && !stall;
    assign mismatch = (data_up != EXP_BEAT[beat_cnt]);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            asm_data    <= '0;
            err_acc     <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            abort_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_up && ready_up) begin
                        asm_data <= pack_beat('0, data_up);
                        err_acc  <= mismatch;
                        if (BEATS == 1) begin
                            frame_data  <= pack_beat('0, data_up);
                            frame_err   <= mismatch;
                            frame_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            beat_cnt <= CNT_W'(1);
                            state    <= RECV;
                        end
                    end
                end
                RECV: begin
                    // Dropping valid mid-frame means the master restarted its sequence.
                    if (!valid_up) begin
                        if (abort_cnt != 8'hFF) begin
                            abort_cnt <= abort_cnt + 8'd1;
                        end
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (ready_up) begin
                        asm_data <= pack_beat(asm_data, data_up);
                        err_acc  <= err_acc | mismatch;
                        if (beat_cnt == CNT_W'(BEATS - 1)) begin
                            frame_data  <= pack_beat(asm_data, data_up);
                            frame_err   <= err_acc | mismatch;
                            frame_valid <= 1'b1;
                            beat_cnt    <= '0;
                            state       <= HOLD;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_rx.sv
// Directed bench for slave_rx; define BACKPRESSURE_EN to also cover the ready throttle.
module tb_slave_rx;

    logic       sys_clk;
    logic       sys_rst;
    logic       valid_up;
    logic [2:0] data_up;
    logic       ready_up;
    logic [8:0] frame_data;
    logic       frame_valid;
    logic       frame_err;
    logic       frame_ready;
    logic [7:0] abort_cnt;

    int assertions;
    int failures;

    slave_rx dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .valid_up    (valid_up),
        .data_up     (data_up),
        .ready_up    (ready_up),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .frame_ready (frame_ready),
        .abort_cnt   (abort_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Present one beat and hold it until a cycle with ready_up high; returns #1 after the accept edge.
    task automatic send_beat(input logic [2:0] d);
        bit ok;
        ok = 1'b0;
        valid_up = 1'b1;
        data_up  = d;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge sys_clk);
            if (ready_up) ok = 1'b1;
            @(posedge sys_clk);
            #1;
        end
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL beat_accept_timeout data=%b ready_up=%b required 1", d, ready_up);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        valid_up = 1'b0;
        data_up = 3'b000;
        frame_ready = 1'b1;
        #12;
        assertions++;
        if ({frame_valid, frame_err, frame_data, abort_cnt} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b err=%b data=%h abort=%0d required all 0",
                     frame_valid, frame_err, frame_data, abort_cnt);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        assertions++;
        if (frame_valid !== 1'b0 || abort_cnt !== 8'd0) begin
            failures++;
            $display("FAIL post_reset valid=%b abort=%0d required 0/0", frame_valid, abort_cnt);
        end
`ifndef BACKPRESSURE_EN
        assertions++;
        if (ready_up !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready ready_up=%b required 1", ready_up);
        end
`endif
    endtask

    task automatic test_good_frame();
        send_beat(3'b111);
        send_beat(3'b101);
        assertions++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL early_valid frame_valid=%b required 0", frame_valid);
        end
        send_beat(3'b110);
        valid_up = 1'b0;
        assertions++;
        if (frame_valid !== 1'b1 || frame_data !== 9'h1EE || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL good_frame valid=%b data=%h err=%b required 1/1ee/0",
                     frame_valid, frame_data, frame_err);
        end
    endtask

    task automatic test_error_frame();
        send_beat(3'b111);
        send_beat(3'b100);
        send_beat(3'b110);
        valid_up = 1'b0;
        assertions++;
        if (frame_valid !== 1'b1 || frame_data !== 9'h1E6 || frame_err !== 1'b1) begin
            failures++;
            $display("FAIL err_frame valid=%b data=%h err=%b required 1/1e6/1",
                     frame_valid, frame_data, frame_err);
        end
        send_beat(3'b111);
        send_beat(3'b101);
        send_beat(3'b110);
        valid_up = 1'b0;
        assertions++;
        if (frame_valid !== 1'b1 || frame_data !== 9'h1EE || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared valid=%b data=%h err=%b required 1/1ee/0",
                     frame_valid, frame_data, frame_err);
        end
    endtask

    task automatic test_hold();
        @(posedge sys_clk);
        #1;
        frame_ready = 1'b0;
        send_beat(3'b111);
        send_beat(3'b101);
        send_beat(3'b110);
        valid_up = 1'b0;
        for (int i = 0; i < 5; i++) begin
            assertions++;
            if (ready_up !== 1'b0 || frame_valid !== 1'b1 || frame_data !== 9'h1EE) begin
                failures++;
                $display("FAIL hold_cycle%0d ready=%b valid=%b data=%h required 0/1/1ee",
                         i, ready_up, frame_valid, frame_data);
            end
            @(posedge sys_clk);
            #1;
        end
        frame_ready = 1'b1;
        assertions++;
        if (ready_up !== 1'b0) begin
            failures++;
            $display("FAIL consume_bubble ready_up=%b required 0", ready_up);
        end
        @(posedge sys_clk);
        #1;
        assertions++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL consumed frame_valid=%b required 0", frame_valid);
        end
`ifndef BACKPRESSURE_EN
        assertions++;
        if (ready_up !== 1'b1) begin
            failures++;
            $display("FAIL after_consume ready_up=%b required 1", ready_up);
        end
`endif
    endtask

    task automatic test_abort();
        send_beat(3'b111);
        send_beat(3'b101);
        valid_up = 1'b0;
        @(posedge sys_clk);
        #1;
        assertions++;
        if (abort_cnt !== 8'd1 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort abort_cnt=%0d valid=%b required 1/0", abort_cnt, frame_valid);
        end
        send_beat(3'b111);
        send_beat(3'b101);
        send_beat(3'b110);
        valid_up = 1'b0;
        assertions++;
        if (frame_valid !== 1'b1 || frame_data !== 9'h1EE || frame_err !== 1'b0 || abort_cnt !== 8'd1) begin
            failures++;
            $display("FAIL restart_frame valid=%b data=%h err=%b abort=%0d required 1/1ee/0/1",
                     frame_valid, frame_data, frame_err, abort_cnt);
        end
    endtask

    task automatic test_async_reset();
        @(posedge sys_clk);
        #1;
        send_beat(3'b111);
        valid_up = 1'b0;
        data_up = 3'b101;
        #3;
        sys_rst = 1'b1;
        #1;
        assertions++;
        if ({frame_valid, frame_err, frame_data, abort_cnt} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset valid=%b err=%b data=%h abort=%0d required all 0",
                     frame_valid, frame_err, frame_data, abort_cnt);
        end
        #2;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        send_beat(3'b111);
        send_beat(3'b101);
        send_beat(3'b110);
        valid_up = 1'b0;
        assertions++;
        if (frame_valid !== 1'b1 || frame_data !== 9'h1EE || frame_err !== 1'b0 || abort_cnt !== 8'd0) begin
            failures++;
            $display("FAIL post_reset_frame valid=%b data=%h err=%b abort=%0d required 1/1ee/0/0",
                     frame_valid, frame_data, frame_err, abort_cnt);
        end
    endtask

`ifdef BACKPRESSURE_EN
    task automatic test_backpressure();
        logic [7:0] mask;
        mask = 8'hA4;
        valid_up = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            assertions++;
            if (ready_up !== ~mask[k % 8]) begin
                failures++;
                $display("FAIL stall_pattern k=%0d ready_up=%b required %b", k, ready_up, ~mask[k % 8]);
            end
            @(posedge sys_clk);
        end
        #1;
        send_beat(3'b111);
        send_beat(3'b101);
        send_beat(3'b110);
        valid_up = 1'b0;
        assertions++;
        if (frame_valid !== 1'b1 || frame_data !== 9'h1EE || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_frame valid=%b data=%h err=%b required 1/1ee/0",
                     frame_valid, frame_data, frame_err);
        end
    endtask
`endif

    initial begin
        assertions = 0;
        failures = 0;
        test_reset();
        test_good_frame();
        test_error_frame();
        test_hold();
        test_abort();
        test_async_reset();
`ifdef BACKPRESSURE_EN
        test_backpressure();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
